// File: rtl/i2s_tx_ctrl.sv
// i2s_tx_ctrl: left-justified I2S transmitter with programmable bit clock, one-pair sample buffer and underrun counter
module i2s_tx_ctrl #(
  parameter int DIV_W  = 8,
  parameter int UCNT_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              stereo,
  input  logic [DIV_W-1:0]  bclk_div,
  input  logic [15:0]       sample_l,
  input  logic [15:0]       sample_r,
  input  logic              sample_valid,
  output logic              sample_ready,
  output logic              hp_bck,
  output logic              hp_ws,
  output logic              hp_din,
  output logic              frame_start,
  output logic [UCNT_W-1:0] underrun_cnt
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state_q, state_d;
  logic bck_q, bck_d, full_q, full_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [4:0] bit_cnt_q, bit_cnt_d;
  logic [31:0] shift_q, shift_d, hold_q, hold_d, last_q, last_d;
  logic [UCNT_W-1:0] ucnt_q, ucnt_d;
  logic run, tick, fall, load, cap;
  always_comb begin
    run = state_q == RUN && enable;
    cap = sample_valid && !full_q && !reset;
    tick = cnt_q >= bclk_div;
    fall = run && tick && bck_q;
    load = enable && (state_q == IDLE || (fall && bit_cnt_q == 5'd31));
    state_d = enable ? RUN : IDLE;
    cnt_d = (run && !tick) ? cnt_q + DIV_W'(1) : '0;
    bck_d = run && (tick ? !bck_q : bck_q);
    bit_cnt_d = (!enable || load) ? 5'd0 : bit_cnt_q + 5'(fall);
    shift_d = load ? (full_q ? hold_q : last_q) : fall ? {shift_q[30:0], 1'b0} : shift_q;
    last_d = (load && full_q) ? hold_q : last_q;
    // a load in the same cycle as a capture consumes the old (empty) buffer; the capture survives
    full_d = cap || (full_q && !load);
    hold_d = cap ? {sample_l, stereo ? sample_r : sample_l} : hold_q;
    ucnt_d = (load && !full_q && ucnt_q != '1) ? ucnt_q + UCNT_W'(1) : ucnt_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      bck_q <= 1'b0;
      bit_cnt_q <= '0;
      shift_q <= '0;
      hold_q <= '0;
      last_q <= '0;
      full_q <= 1'b0;
      ucnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      bck_q <= bck_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q <= shift_d;
      hold_q <= hold_d;
      last_q <= last_d;
      full_q <= full_d;
      ucnt_q <= ucnt_d;
    end
  end
  assign sample_ready = !full_q && !reset;
  assign hp_bck = bck_q;
  assign hp_ws = state_q == RUN && bit_cnt_q[4];
  assign hp_din = state_q == RUN && shift_q[31];
  assign frame_start = load && !reset;
  assign underrun_cnt = ucnt_q;
endmodule
